// File: rtl/sdram_responder.sv
// SDRAM device-side behavioural responder (single data rate, 32-bit data).
// Decodes the SDRAM command bus, tracks per-bank open rows, runs read/write
// bursts against an internal array and returns read data after CAS latency.
// Ports:
//   DRAM_CLK, rst                            clock, synchronous active-high reset
//   DRAM_CS_N/RAS_N/CAS_N/WE_N, DRAM_CKE     command bus and clock enable
//   DRAM_BA, DRAM_ADDR, DRAM_DQM, dq_in      bank, address, byte masks, write data
//   dq_out, dq_oe                            read data and its valid/drive enable
//   init_done, err_cnt                       mode programmed, saturating error count
module sdram_responder #(
    parameter int unsigned ROW_BITS = 2,
    parameter int unsigned COL_BITS = 4
) (
    input  logic        DRAM_CLK,
    input  logic        rst,
    input  logic        DRAM_CS_N,
    input  logic        DRAM_RAS_N,
    input  logic        DRAM_CAS_N,
    input  logic        DRAM_WE_N,
    input  logic        DRAM_CKE,
    input  logic [1:0]  DRAM_BA,
    input  logic [12:0] DRAM_ADDR,
    input  logic [3:0]  DRAM_DQM,
    input  logic [31:0] dq_in,
    output logic [31:0] dq_out,
    output logic        dq_oe,
    output logic        init_done,
    output logic [7:0]  err_cnt
);
    localparam int unsigned AW    = 2 + ROW_BITS + COL_BITS;
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [2:0] CMD_MRS = 3'b000;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_BST = 3'b110;

    logic [31:0]         mem [DEPTH];
    logic [3:0]          bank_act;
    logic [ROW_BITS-1:0] bank_row [4];
    logic [2:0]          bl_code;
    logic                cl3;
    logic                wsingle;

    // Burst engine: word k of a burst accesses column base/mask-wrapped k
    logic                b_act, b_rd, b_full, b_ap;
    logic [1:0]          b_bank;
    logic [ROW_BITS-1:0] b_row;
    logic [COL_BITS-1:0] b_base, b_k, b_mask;

    // Read pipeline between column access and dq_out register
    logic                p1_v, p2_v;
    logic [31:0]         p1_d, p2_d;

    logic                sel, is_act, is_rd, is_wr, is_pre, is_ref, is_mrs, is_bst;
    logic [2:0]          cmd;
    logic                mrs_ok, rw_ok, err, pre_hit, cont, b_last;
    logic                new_single, new_full;
    logic [COL_BITS-1:0] new_mask;
    logic                acc_en, acc_rd;
    logic [1:0]          acc_bank;
    logic [ROW_BITS-1:0] acc_row;
    logic [COL_BITS-1:0] acc_col;
    logic [AW-1:0]       acc_idx;
    logic [31:0]         rd_word;
    logic                unused_addr;

    assign unused_addr = ^DRAM_ADDR;

    function automatic logic [COL_BITS-1:0] bl_mask(input logic [2:0] c);
        case (c)
            3'b001:  bl_mask = COL_BITS'(1);
            3'b010:  bl_mask = COL_BITS'(3);
            3'b011:  bl_mask = COL_BITS'(7);
            3'b111:  bl_mask = '1;
            default: bl_mask = '0;
        endcase
    endfunction

    // Command decode, error detection and column-access selection
    always_comb begin
        cmd     = {DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N};
        sel     = DRAM_CKE && !DRAM_CS_N;
        is_act  = sel && (cmd == CMD_ACT);
        is_rd   = sel && (cmd == CMD_RD);
        is_wr   = sel && (cmd == CMD_WR);
        is_pre  = sel && (cmd == CMD_PRE);
        is_ref  = sel && (cmd == CMD_REF);
        is_mrs  = sel && (cmd == CMD_MRS);
        is_bst  = sel && (cmd == CMD_BST);

        mrs_ok  = (DRAM_ADDR[2:0] inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b111}) &&
                  (DRAM_ADDR[6:4] inside {3'b010, 3'b011});
        rw_ok   = (is_rd || is_wr) && init_done && bank_act[DRAM_BA];

        err = 1'b0;
        if (!init_done) err = is_act || is_rd || is_wr || is_bst;
        else            err = (is_act && bank_act[DRAM_BA]) ||
                              ((is_rd || is_wr) && !bank_act[DRAM_BA]);
        if (is_ref && (|bank_act)) err = 1'b1;
        if (is_mrs && !mrs_ok)     err = 1'b1;

        new_single = (is_wr && wsingle) || (bl_code == 3'b000);
        new_full   = (bl_code == 3'b111) && !(is_wr && wsingle);
        new_mask   = (is_wr && wsingle) ? '0 : bl_mask(bl_code);

        pre_hit = is_pre && (DRAM_ADDR[10] || (DRAM_BA == b_bank));
        cont    = DRAM_CKE && b_act && !rw_ok && !is_bst && !pre_hit;
        b_last  = cont && !b_full && (b_k == b_mask);

        acc_en   = 1'b0;
        acc_rd   = 1'b0;
        acc_bank = DRAM_BA;
        acc_row  = bank_row[DRAM_BA];
        acc_col  = DRAM_ADDR[COL_BITS-1:0];
        if (rw_ok) begin
            acc_en = 1'b1;
            acc_rd = is_rd;
        end else if (cont) begin
            acc_en   = 1'b1;
            acc_rd   = b_rd;
            acc_bank = b_bank;
            acc_row  = b_row;
            acc_col  = (b_base & ~b_mask) | ((b_base + b_k) & b_mask);
        end
        acc_idx = {acc_bank, acc_row, acc_col};
        rd_word = mem[acc_idx];
    end

    // Memory array: never reset; writes suppressed on the reset edge
    always_ff @(posedge DRAM_CLK) begin
        if (!rst && acc_en && !acc_rd) begin
            for (int i = 0; i < 4; i++) begin
                if (!DRAM_DQM[i]) mem[acc_idx][8*i +: 8] <= dq_in[8*i +: 8];
            end
        end
    end

    // Control state, burst engine and read pipeline; all frozen while CKE=0
    always_ff @(posedge DRAM_CLK) begin
        if (rst) begin
            bank_act  <= '0;
            for (int i = 0; i < 4; i++) bank_row[i] <= '0;
            bl_code   <= 3'b111;
            cl3       <= 1'b0;
            wsingle   <= 1'b0;
            init_done <= 1'b0;
            err_cnt   <= '0;
            b_act     <= 1'b0;
            b_rd      <= 1'b0;
            b_full    <= 1'b0;
            b_ap      <= 1'b0;
            b_bank    <= '0;
            b_row     <= '0;
            b_base    <= '0;
            b_k       <= '0;
            b_mask    <= '0;
            p1_v      <= 1'b0;
            p1_d      <= '0;
            p2_v      <= 1'b0;
            p2_d      <= '0;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
        end else if (DRAM_CKE) begin
            if (err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;

            if (is_mrs && mrs_ok) begin
                bl_code   <= DRAM_ADDR[2:0];
                cl3       <= DRAM_ADDR[4];
                wsingle   <= DRAM_ADDR[9];
                init_done <= 1'b1;
            end

            if (is_act && init_done && !bank_act[DRAM_BA]) begin
                bank_act[DRAM_BA] <= 1'b1;
                bank_row[DRAM_BA] <= DRAM_ADDR[ROW_BITS-1:0];
            end

            if (is_pre) begin
                if (DRAM_ADDR[10]) bank_act <= '0;
                else               bank_act[DRAM_BA] <= 1'b0;
            end

            // Word 0 is accessed on the command edge; the engine runs words 1..
            if (rw_ok) begin
                b_act  <= !new_single;
                b_rd   <= is_rd;
                b_full <= new_full;
                b_ap   <= DRAM_ADDR[10];
                b_bank <= DRAM_BA;
                b_row  <= bank_row[DRAM_BA];
                b_base <= DRAM_ADDR[COL_BITS-1:0];
                b_k    <= COL_BITS'(1);
                b_mask <= new_mask;
                if (new_single && DRAM_ADDR[10]) bank_act[DRAM_BA] <= 1'b0;
            end else if (cont) begin
                if (b_last) begin
                    b_act <= 1'b0;
                    if (b_ap) bank_act[b_bank] <= 1'b0;
                end else begin
                    b_k <= b_k + COL_BITS'(1);
                end
            end else begin
                b_act <= 1'b0;
            end

            // CL2 takes stage 1, CL3 stage 2: word lands on dq one edge before sampling
            p1_v <= acc_en && acc_rd;
            p1_d <= rd_word;
            p2_v <= p1_v;
            p2_d <= p1_d;
            if (cl3) begin
                dq_oe  <= p2_v;
                dq_out <= p2_v ? p2_d : 32'd0;
            end else begin
                dq_oe  <= p1_v;
                dq_out <= p1_v ? p1_d : 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_sdram_responder.sv
// Self-checking bench for sdram_responder: a table of directed command
// vectors with hand-computed expected outputs, followed by hand-written
// sequences for clock-enable stall, reset mid-burst and protocol errors.
module tb_sdram_responder;
    localparam logic [2:0] MRS = 3'b000;
    localparam logic [2:0] PRE = 3'b010;
    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] WR  = 3'b100;
    localparam logic [2:0] RD  = 3'b101;
    localparam logic [2:0] BST = 3'b110;
    localparam logic [2:0] NOP = 3'b111;

    localparam logic [31:0] WA = 32'hAAAA_0001;
    localparam logic [31:0] WB = 32'hBBBB_0002;
    localparam logic [31:0] WC = 32'hCCCC_0003;
    localparam logic [31:0] WD = 32'hDDDD_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n, ras_n, cas_n, we_n, cke;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [3:0]  dqm;
    logic [31:0] dq_in;
    logic [31:0] dq_out;
    logic        dq_oe;
    logic        init_done;
    logic [7:0]  err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        cke;
        logic [2:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic [3:0]  dqm;
        logic [31:0] din;
        logic        oe;
        logic [31:0] dq;
        logic [7:0]  err;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    sdram_responder #(.ROW_BITS(2), .COL_BITS(4)) dut (
        .DRAM_CLK   (clk),
        .rst        (rst),
        .DRAM_CS_N  (cs_n),
        .DRAM_RAS_N (ras_n),
        .DRAM_CAS_N (cas_n),
        .DRAM_WE_N  (we_n),
        .DRAM_CKE   (cke),
        .DRAM_BA    (ba),
        .DRAM_ADDR  (addr),
        .DRAM_DQM   (dqm),
        .dq_in      (dq_in),
        .dq_out     (dq_out),
        .dq_oe      (dq_oe),
        .init_done  (init_done),
        .err_cnt    (err_cnt)
    );

    task automatic add(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [31:0] d, input logic [3:0] m,
                       input logic oe, input logic [31:0] q, input logic [7:0] e);
        vec_t v;
        v.cke = 1'b1; v.cmd = c; v.ba = b; v.addr = a; v.dqm = m; v.din = d;
        v.oe = oe; v.dq = q; v.err = e;
        vq.push_back(v);
    endtask

    task automatic drv(input logic k, input logic [2:0] c, input logic [1:0] b,
                       input logic [12:0] a, input logic [31:0] d, input logic [3:0] m);
        cke = k; cs_n = 1'b0; {ras_n, cas_n, we_n} = c; ba = b; addr = a; dq_in = d; dqm = m;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cmp_out(input string name, input logic oe, input logic [31:0] q, input logic [7:0] e);
        cmp({name, "_oe"},  {31'd0, dq_oe}, {31'd0, oe});
        cmp({name, "_dq"},  dq_out, q);
        cmp({name, "_err"}, {24'd0, err_cnt}, {24'd0, e});
    endtask

    initial begin
        rst = 1'b1;
        drv(1'b1, NOP, 2'd0, 13'd0, 32'd0, 4'd0);
        step();
        step();
        cmp("reset_oe",   {31'd0, dq_oe}, 32'd0);
        cmp("reset_dq",   dq_out, 32'd0);
        cmp("reset_init", {31'd0, init_done}, 32'd0);
        cmp("reset_err",  {24'd0, err_cnt}, 32'd0);
        rst = 1'b0;

        // Full page CL2: write 16 words, BST, read back with wrap
        add(MRS, 0, 13'h027, 0, 0, 0, 0, 0);
        add(ACT, 1, 13'd2,   0, 0, 0, 0, 0);
        add(WR,  1, 13'd0, 32'h800, 0, 0, 0, 0);
        for (int i = 1; i < 16; i++) add(NOP, 0, 0, 32'h800 + 32'(i), 0, 0, 0, 0);
        add(BST, 0, 0, 32'hDEAD, 0, 0, 0, 0);
        add(RD,  1, 13'd0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 17; k++) add(NOP, 0, 0, 0, 0, 1, 32'h800 + 32'(k % 16), 0);
        add(BST, 0, 0, 0, 0, 1, 32'h801, 0);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);

        // BL4 CL3: write col6 wraps 6,7,4,5 within the aligned block
        add(MRS, 0, 13'h032, 0, 0, 0, 0, 0);
        add(WR,  1, 13'd6, WA, 0, 0, 0, 0);
        add(NOP, 0, 0, WB, 0, 0, 0, 0);
        add(NOP, 0, 0, WC, 0, 0, 0, 0);
        add(NOP, 0, 0, WD, 0, 0, 0, 0);
        add(NOP, 0, 0, 32'hBAD, 0, 0, 0, 0);
        add(RD,  1, 13'd6, 0, 0, 0, 0, 0);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);
        add(NOP, 0, 0, 0, 0, 1, WA, 0);
        add(NOP, 0, 0, 0, 0, 1, WB, 0);
        add(NOP, 0, 0, 0, 0, 1, WC, 0);
        add(NOP, 0, 0, 0, 0, 1, WD, 0);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);
        add(RD,  1, 13'd4, 0, 0, 0, 0, 0);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);
        add(NOP, 0, 0, 0, 0, 1, WC, 0);
        add(NOP, 0, 0, 0, 0, 1, WD, 0);
        add(NOP, 0, 0, 0, 0, 1, WA, 0);
        add(NOP, 0, 0, 0, 0, 1, WB, 0);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);

        // Write-single with full-page reads; BST cuts the read after two words
        add(MRS, 0, 13'h227, 0, 0, 0, 0, 0);
        add(WR,  1, 13'd1, 32'hAAA, 0, 0, 0, 0);
        add(WR,  1, 13'd0, 32'h111, 0, 0, 0, 0);
        add(NOP, 0, 0, 32'h222, 0, 0, 0, 0);
        add(RD,  1, 13'd0, 0, 0, 0, 0, 0);
        add(NOP, 0, 0, 0, 0, 1, 32'h111, 0);
        add(BST, 0, 0, 0, 0, 1, 32'hAAA, 0);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);

        // BL1: byte masks, then READ with auto-precharge closes the bank
        add(MRS, 0, 13'h020, 0, 0, 0, 0, 0);
        add(WR,  1, 13'd3, 32'h1234_5678, 4'b0000, 0, 0, 0);
        add(WR,  1, 13'd3, 32'hFFFF_FFFF, 4'b0101, 0, 0, 0);
        add(RD,  1, 13'h403, 0, 0, 0, 0, 0);
        add(NOP, 0, 0, 0, 0, 1, 32'hFF34_FF78, 0);
        add(RD,  1, 13'd3, 0, 0, 0, 0, 1);
        add(NOP, 0, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            drv(vq[i].cke, vq[i].cmd, vq[i].ba, vq[i].addr, vq[i].din, vq[i].dqm);
            step();
            cmp_out($sformatf("vec%0d", i), vq[i].oe, vq[i].dq, vq[i].err);
        end

        // CKE stall mid full-page read: held word, then no skip or repeat
        drv(1, MRS, 0, 13'h027, 0, 0); step();
        drv(1, ACT, 1, 13'd2, 0, 0);   step();
        drv(1, RD,  1, 13'd0, 0, 0);   step(); cmp_out("cke_rd", 0, 0, 1);
        drv(1, NOP, 0, 0, 0, 0);       step(); cmp_out("cke_w0", 1, 32'h111, 1);
        step();                                cmp_out("cke_w1", 1, 32'hAAA, 1);
        for (int i = 0; i < 3; i++) begin
            drv(0, RD, 1, 13'd5, 0, 0); step();
            cmp_out($sformatf("cke_hold%0d", i), 1, 32'hAAA, 1);
        end
        drv(1, NOP, 0, 0, 0, 0);       step(); cmp_out("cke_w2", 1, 32'h802, 1);
        step();                                cmp_out("cke_w3", 1, 32'hFF34_FF78, 1);
        step();                                cmp_out("cke_w4", 1, WC, 1);
        step();                                cmp_out("cke_w5", 1, WD, 1);
        drv(1, BST, 0, 0, 0, 0);       step(); cmp_out("cke_w6", 1, WA, 1);
        drv(1, NOP, 0, 0, 0, 0);       step(); cmp_out("cke_end", 0, 0, 1);

        // Reset in the middle of a full-page write burst
        drv(1, ACT, 3, 13'd0, 0, 0);   step();
        drv(1, WR,  3, 13'd0, 32'h3000, 0); step();
        for (int i = 1; i < 8; i++) begin drv(1, NOP, 0, 0, 32'h3000 + 32'(i), 0); step(); end
        drv(1, BST, 0, 0, 0, 0);       step();
        drv(1, WR,  3, 13'd0, 32'h4000, 0); step();
        drv(1, NOP, 0, 0, 32'h4001, 0); step();
        drv(1, NOP, 0, 0, 32'h4002, 0); step();
        rst = 1'b1;
        drv(1, NOP, 0, 0, 32'h4003, 0); step();
        cmp("rst_oe",   {31'd0, dq_oe}, 32'd0);
        cmp("rst_init", {31'd0, init_done}, 32'd0);
        cmp("rst_err",  {24'd0, err_cnt}, 32'd0);
        rst = 1'b0;
        drv(1, NOP, 0, 0, 32'h4004, 0); step(); cmp_out("rst_after", 0, 0, 0);

        // Protocol errors: ACT before MRS, ACT to active bank, READ to idle bank
        drv(1, ACT, 3, 13'd0, 0, 0);   step(); cmp_out("err_act_noinit", 0, 0, 1);
        cmp("err_init0", {31'd0, init_done}, 32'd0);
        drv(1, MRS, 0, 13'h027, 0, 0); step(); cmp_out("err_mrs", 0, 0, 1);
        cmp("err_init1", {31'd0, init_done}, 32'd1);
        drv(1, ACT, 3, 13'd0, 0, 0);   step(); cmp_out("err_act_ok", 0, 0, 1);
        drv(1, ACT, 3, 13'd1, 0, 0);   step(); cmp_out("err_act_twice", 0, 0, 2);
        drv(1, RD,  0, 13'd0, 0, 0);   step(); cmp_out("err_rd_idle", 0, 0, 3);
        for (int i = 0; i < 3; i++) begin
            drv(1, RD, 0, 13'd0, 0, 0); cs_n = 1'b1; step();
            cmp_out($sformatf("err_quiet%0d", i), 0, 0, 3);
        end

        // Readback: row unchanged by the rejected ACT, reset blocked word 3
        drv(1, RD,  3, 13'd0, 0, 0);   step(); cmp_out("rb_rd", 0, 0, 3);
        drv(1, NOP, 0, 0, 0, 0);       step(); cmp_out("rb_w0", 1, 32'h4000, 3);
        step();                                cmp_out("rb_w1", 1, 32'h4001, 3);
        step();                                cmp_out("rb_w2", 1, 32'h4002, 3);
        step();                                cmp_out("rb_w3", 1, 32'h3003, 3);
        step();                                cmp_out("rb_w4", 1, 32'h3004, 3);
        drv(1, PRE, 3, 13'd0, 0, 0);   step(); cmp_out("rb_pre", 1, 32'h3005, 3);
        drv(1, NOP, 0, 0, 0, 0);       step(); cmp_out("rb_end", 0, 0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sdram_responder.md
SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 SHALL have parameter ROW_BITS, default 2, number of stored row-address bits per bank.
REQ-002 SHALL have parameter COL_BITS, default 4, number of stored column bits; full page = 2^COL_BITS words.
REQ-003 SHALL have port DRAM_CLK  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N  input  1 each  command bus.
REQ-006 SHALL have ports DRAM_CKE  input  1  clock enable; DRAM_BA  input  2  bank; DRAM_ADDR  input  13  row/column/mode address.
REQ-007 SHALL have ports DRAM_DQM  input  4  write byte masks; dq_in  input  32  write data.
REQ-008 SHALL have ports dq_out  output  32  read data; dq_oe  output  1  read data valid/drive enable.
REQ-009 SHALL have ports init_done  output  1  mode register programmed; err_cnt  output  8  saturating protocol-error count.

Function
REQ-010 SHALL decode on each edge with DRAM_CKE=1, CS_N=0, {RAS_N,CAS_N,WE_N}: 011 ACT, 101 READ, 100 WRITE, 010 PRE, 001 REF, 000 MRS, 110 BST, 111 NOP; CS_N=1 is NOP.
REQ-011 SHALL ignore commands and freeze all state, including the burst engine and read pipeline, on edges where DRAM_CKE=0.
REQ-012 SHALL store per bank an active flag and open row (DRAM_ADDR[ROW_BITS-1:0]); memory is 4 x 2^ROW_BITS x 2^COL_BITS x 32 bits.
REQ-013 MRS SHALL latch BL=ADDR[2:0] (000=1, 001=2, 010=4, 011=8, 111=full page), CL=ADDR[6:4] (2 or 3), write-single=ADDR[9], and set init_done; other BL/CL codes increment err_cnt and are not latched.
REQ-014 ACT SHALL open the row in DRAM_BA; ACT to an already active bank increments err_cnt and leaves the row unchanged.
REQ-015 PRE SHALL close DRAM_BA, or all banks when ADDR[10]=1; PRE to idle bank is legal.
REQ-016 REF SHALL be accepted only with all banks idle; otherwise increment err_cnt.
REQ-017 WRITE at edge n SHALL store dq_in at column ADDR[COL_BITS-1:0] at edge n, then successive columns each following edge for BL words total (1 if write-single).
REQ-018 Write bytes with DRAM_DQM[i]=1 SHALL retain old contents of byte i.
REQ-019 READ at edge n SHALL drive word k of the burst on dq_out with dq_oe=1 so the initiator samples it at edge n+CL+k.
REQ-020 Burst column SHALL wrap within the page: full page wraps 2^COL_BITS-1 to 0 and continues until interrupted; BL 2/4/8 wrap within the aligned block (sequential order).
REQ-021 A new READ/WRITE SHALL terminate the current burst at that edge; read words already issued to the CL pipeline still appear.
REQ-022 BST or PRE to the bursting bank SHALL stop further column accesses from that edge; pipelined read words drain.
REQ-023 READ/WRITE to an idle bank, or any non-NOP/PRE/REF/MRS command while init_done=0, SHALL increment err_cnt and be otherwise ignored.
REQ-024 READ/WRITE SHALL use the bank's open row; ADDR[10]=1 with READ/WRITE SHALL auto-precharge that bank after the last burst word.
REQ-025 dq_out SHALL be 0 when dq_oe=0.
REQ-026 err_cnt SHALL saturate at 255; two errors cannot occur on one edge.

Reset
REQ-027 On rst: all banks idle, burst engine idle, read pipeline flushed, dq_oe=0, dq_out=0, init_done=0, err_cnt=0, BL=full page, CL=2, write-single=0.
REQ-028 Memory array contents SHALL NOT be reset; rst mid-burst SHALL abort with no further writes and dq_oe=0 the following cycle.

Verification
REQ-029 MRS 0x027 (BL full, CL2), ACT bank1 row2, WRITE col0 with data 0x800..0x80F on 16 edges, BST, READ col0 -> dq_oe=1 at edge read+2, words 0x800..0x80F then wrap to 0x800.
REQ-030 MRS 0x032 (BL4, CL3), WRITE col6 data A,B,C,D -> columns 6,7,4,5; READ col6 -> A,B,C,D sampled at edges n+3..n+6.
REQ-031 WRITE with DRAM_DQM=4'b0101 data 0xFFFFFFFF over 0x12345678 -> read returns 0xFF34FF78.
REQ-032 READ to idle bank, ACT to active bank, ACT before MRS -> err_cnt=3, no dq_oe activity, memory unchanged.
REQ-033 READ full page CL2, DRAM_CKE=0 for 3 edges mid-burst -> output word held, sequence resumes without skipped or duplicated words.
REQ-034 rst asserted mid-write-burst -> dq_oe=0, init_done=0, err_cnt=0; previously written words readable after re-MRS/ACT.
